// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and constants for the memory request front-end and its bench.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  typedef struct packed {
    logic                  wr_rd;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } ctrl_state_e;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Request, response and memory-port bundle of mem_req_ctrl.
interface mem_req_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr_rd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_rd;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  logic              busy;

  modport slave (
    input  req_valid, req_wr_rd, req_addr, req_wdata, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_rd, mem_wr_data, busy
  );

  modport master (
    output req_valid, req_wr_rd, req_addr, req_wdata, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr_rd, mem_wr_data, busy
  );

endinterface

// File: rtl/mem_req_fifo.sv
// In-order request FIFO; full/empty derive from the registered count only.
module mem_req_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = req_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  entry_t           store [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = store[rptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wptr] <= din;
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Sequences queued read/write requests onto a single-port memory and
// returns read data on a valid/ready response channel, one read in flight.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  mem_req_ctrl_if.slave bus
);

  typedef struct packed {
    logic              wr_rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  entry_t            push_ent;
  entry_t            head;
  logic              full;
  logic              empty;
  logic              pop;

  ctrl_state_e       state;
  logic [2:0]        lat_cnt;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_rd;
  logic [DATA_W-1:0] mem_wr_data;

  assign push_ent = '{wr_rd: bus.req_wr_rd, addr: bus.req_addr, wdata: bus.req_wdata};

  // A pop is only ever taken when the issue slot is free: idle, or the
  // pending response is being handed off on this very edge.
  assign pop = !empty && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));

  mem_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid),
    .pop   (pop),
    .din   (push_ent),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      mem_addr    <= '0;
      mem_wr_rd   <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_rd <= 1'b0;
      if ((state == RESP) && bus.rsp_ready) rsp_valid <= 1'b0;
      if (pop) begin
        mem_addr <= head.addr;
        if (head.wr_rd == WR) begin
          mem_wr_rd   <= 1'b1;
          mem_wr_data <= head.wdata;
          state       <= IDLE;
        end else begin
          lat_cnt <= LAT_INIT;
          state   <= WAIT;
        end
      end else begin
        case (state)
          WAIT: begin
            if (lat_cnt == '0) begin
              rsp_rdata <= bus.mem_rd_data;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
          RESP: begin
            if (bus.rsp_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready   = !full;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wr_rd   = mem_wr_rd;
  assign bus.mem_wr_data = mem_wr_data;
  assign bus.busy        = !empty || (state != IDLE) || rsp_valid;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: table of single-cycle vectors plus
// hand-written backpressure, full-FIFO and mid-flight reset sequences.
module tb_mem_req_ctrl;
  import mem_ctrl_pkg::*;

  localparam int TB_RD_LAT = 1;

  logic clk;
  logic rst;

  mem_req_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_req_ctrl #(
    .ADDR_W (8),
    .DATA_W (8),
    .DEPTH  (4),
    .RD_LAT (TB_RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory: write and read both sampled at the edge.
  logic [7:0] mem_arr [256];
  logic [7:0] rd_pipe [TB_RD_LAT];

  always @(posedge clk) begin
    if (bus.mem_wr_rd) mem_arr[bus.mem_addr] <= bus.mem_wr_data;
    rd_pipe[0] <= mem_arr[bus.mem_addr];
    for (int i = 1; i < TB_RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.mem_rd_data = rd_pipe[TB_RD_LAT-1];

  int checks;
  int errors;

  typedef struct {
    logic       vld;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rr;
    logic       e_wr;
    logic [7:0] e_addr;
    logic [7:0] e_wdata;
    logic       e_rdy;
    logic       e_rv;
    logic [7:0] e_rd;
    logic       e_busy;
  } vec_t;

  vec_t vecs [9];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic rr);
    bus.req_valid = v;
    bus.req_wr_rd = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input string name, input logic w, input logic [7:0] a,
                         input logic [7:0] d);
    chk1({name, "_wr_rd"}, bus.mem_wr_rd, w);
    chk8({name, "_addr"}, bus.mem_addr, a);
    chk8({name, "_wdata"}, bus.mem_wr_data, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    //            vld   wr  addr   wdata  rr  | e_wr e_addr e_wdata rdy  rv  e_rd  busy
    vecs[0] = '{1'b1, WR, 8'h05, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{1'b0, RD, 8'h00, 8'h00, 1'b1, 1'b1, 8'h05, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, RD, 8'h00, 8'h00, 1'b1, 1'b0, 8'h05, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, WR, 8'h10, 8'h3C, 1'b1, 1'b0, 8'h05, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{1'b1, RD, 8'h10, 8'h00, 1'b1, 1'b1, 8'h10, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{1'b0, RD, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b0, RD, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[7] = '{1'b0, RD, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1};
    vecs[8] = '{1'b0, RD, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0};

    rst = 1'b0;
    drive(1'b0, RD, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_mem("rst", 1'b0, 8'h00, 8'h00);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk8("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    rst = 1'b1;
    tick();

    // Single write, then write followed by read-after-write.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].vld, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rr);
      tick();
      chk_mem($sformatf("v%0d", i), vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_wdata);
      chk1($sformatf("v%0d_req_ready", i), bus.req_ready, vecs[i].e_rdy);
      chk1($sformatf("v%0d_rsp_valid", i), bus.rsp_valid, vecs[i].e_rv);
      chk8($sformatf("v%0d_rsp_rdata", i), bus.rsp_rdata, vecs[i].e_rd);
      chk1($sformatf("v%0d_busy", i), bus.busy, vecs[i].e_busy);
    end

    // Held read response lets four writes fill the FIFO; a push while full
    // coinciding with the releasing pop must be refused.
    drive(1'b1, RD, 8'h20, 8'h00, 1'b0);
    tick();
    drive(1'b1, WR, 8'h31, 8'h11, 1'b0);
    tick();
    chk_mem("fill_rd", 1'b0, 8'h20, 8'h3C);
    drive(1'b1, WR, 8'h32, 8'h22, 1'b0);
    tick();
    drive(1'b1, WR, 8'h33, 8'h33, 1'b0);
    tick();
    chk1("fill_rsp_valid", bus.rsp_valid, 1'b1);
    chk1("fill3_req_ready", bus.req_ready, 1'b1);
    drive(1'b1, WR, 8'h34, 8'h44, 1'b0);
    tick();
    chk1("fill4_req_ready", bus.req_ready, 1'b0);
    drive(1'b1, WR, 8'hEE, 8'hEE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("full%0d_req_ready", i), bus.req_ready, 1'b0);
      chk1($sformatf("full%0d_rsp_valid", i), bus.rsp_valid, 1'b1);
      chk_mem($sformatf("full%0d", i), 1'b0, 8'h20, 8'h3C);
    end
    drive(1'b1, WR, 8'hEE, 8'hEE, 1'b1);
    tick();
    chk_mem("drain0", 1'b1, 8'h31, 8'h11);
    chk1("drain0_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("drain0_req_ready", bus.req_ready, 1'b1);
    drive(1'b0, RD, 8'h00, 8'h00, 1'b0);
    tick();
    chk_mem("drain1", 1'b1, 8'h32, 8'h22);
    tick();
    chk_mem("drain2", 1'b1, 8'h33, 8'h33);
    tick();
    chk_mem("drain3", 1'b1, 8'h34, 8'h44);
    tick();
    chk_mem("drain4", 1'b0, 8'h34, 8'h44);
    chk1("drain4_busy", bus.busy, 1'b0);

    // Two reads under response backpressure.
    drive(1'b1, WR, 8'h01, 8'h5A, 1'b0);
    tick();
    drive(1'b1, WR, 8'h02, 8'h6B, 1'b0);
    tick();
    chk_mem("bp_w1", 1'b1, 8'h01, 8'h5A);
    drive(1'b1, RD, 8'h01, 8'h00, 1'b0);
    tick();
    chk_mem("bp_w2", 1'b1, 8'h02, 8'h6B);
    drive(1'b1, RD, 8'h02, 8'h00, 1'b0);
    tick();
    chk_mem("bp_r1", 1'b0, 8'h01, 8'h6B);
    drive(1'b0, RD, 8'h00, 8'h00, 1'b0);
    tick();
    chk1("bp_wait_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    chk1("bp_rsp1_valid", bus.rsp_valid, 1'b1);
    chk8("bp_rsp1_rdata", bus.rsp_rdata, 8'h5A);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1($sformatf("bp_hold%0d_valid", i), bus.rsp_valid, 1'b1);
      chk8($sformatf("bp_hold%0d_rdata", i), bus.rsp_rdata, 8'h5A);
      chk8($sformatf("bp_hold%0d_addr", i), bus.mem_addr, 8'h01);
    end
    drive(1'b0, RD, 8'h00, 8'h00, 1'b1);
    tick();
    chk1("bp_hs_valid", bus.rsp_valid, 1'b0);
    chk_mem("bp_r2", 1'b0, 8'h02, 8'h6B);
    tick();
    chk1("bp_r2_wait_valid", bus.rsp_valid, 1'b0);
    tick();
    chk1("bp_rsp2_valid", bus.rsp_valid, 1'b1);
    chk8("bp_rsp2_rdata", bus.rsp_rdata, 8'h6B);
    tick();
    chk1("bp_rsp2_done_valid", bus.rsp_valid, 1'b0);
    chk1("bp_rsp2_done_busy", bus.busy, 1'b0);

    // Reset while a read is in WAIT with three requests still queued.
    drive(1'b1, RD, 8'h07, 8'h00, 1'b0);
    tick();
    drive(1'b1, RD, 8'h05, 8'h00, 1'b0);
    tick();
    drive(1'b1, WR, 8'h41, 8'h01, 1'b0);
    tick();
    drive(1'b1, WR, 8'h42, 8'h02, 1'b0);
    tick();
    drive(1'b1, WR, 8'h43, 8'h03, 1'b0);
    tick();
    chk1("mr_full_req_ready", bus.req_ready, 1'b0);
    drive(1'b0, RD, 8'h00, 8'h00, 1'b1);
    tick();
    chk_mem("mr_issue", 1'b0, 8'h05, 8'h6B);
    chk1("mr_issue_busy", bus.busy, 1'b1);
    drive(1'b0, RD, 8'h00, 8'h00, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_mem("mr_async", 1'b0, 8'h00, 8'h00);
    chk1("mr_async_rsp_valid", bus.rsp_valid, 1'b0);
    chk8("mr_async_rsp_rdata", bus.rsp_rdata, 8'h00);
    chk1("mr_async_busy", bus.busy, 1'b0);
    chk1("mr_async_req_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1($sformatf("mr_post%0d_rsp_valid", i), bus.rsp_valid, 1'b0);
      chk1($sformatf("mr_post%0d_busy", i), bus.busy, 1'b0);
      chk1($sformatf("mr_post%0d_wr_rd", i), bus.mem_wr_rd, 1'b0);
      chk1($sformatf("mr_post%0d_req_ready", i), bus.req_ready, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request front-end that sits directly upstream of the single-port `mem` block and drives its `addr`, `wr_rd` and `wr_data` inputs.
- Accepts read/write requests on a valid/ready channel and buffers them in a small in-order FIFO.
- Sequences each request onto the memory port, waits the memory read latency, and returns read data on a valid/ready response channel.
- Writes are posted and produce no response.

Parameters:
- ADDR_W, 8, width of the memory address.
- DATA_W, 8, width of the memory data.
- DEPTH, 4, request FIFO entries; must be a power of 2 and at least 2.
- RD_LAT, 1, number of clk edges from the edge at which `mem` samples the address to valid `mem_rd_data`; range 1..4.

Ports:
- clk  input  1  single clock; everything is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request FIFO not full.
- req_wr_rd  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  read response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_W  read data.
- mem_addr  output  ADDR_W  to mem `addr`.
- mem_wr_rd  output  1  to mem `wr_rd`; 1 = write.
- mem_wr_data  output  DATA_W  to mem `wr_data`.
- mem_rd_data  input  DATA_W  from mem `rd_data`.
- busy  output  1  FIFO non-empty, or FSM not in IDLE, or rsp_valid high.

Behaviour:
- Reset (rst low, asynchronous): all of the following clear immediately, regardless of clock:
  - FIFO pointers and count go to 0.
  - State goes to IDLE.
  - `req_ready`=1 once reset releases.
  - `rsp_valid`=0, `rsp_rdata`=0.
  - `mem_addr`=0, `mem_wr_rd`=0, `mem_wr_data`=0.
  - `busy`=0.
  - Reset mid-operation discards all queued and in-flight requests; no response is produced for them.
- Request channel:
  - A push occurs on an edge where `req_valid` and `req_ready` are both high.
  - `req_ready` = !full and is registered-state only; it is not combinationally dependent on a same-cycle pop.
  - When the FIFO is full, it does not accept a push even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO are both performed; count is unchanged.
  - FIFO pointers wrap modulo DEPTH.
- All mem_* outputs are registered. `mem_addr` and `mem_wr_data` hold their last value when idle. `mem_wr_rd` returns to 0 whenever no write is being issued.
- FSM states and transitions:
  - IDLE:
    - Pop the head on the first edge the FIFO is non-empty.
    - If the head is a write: drive `mem_wr_rd`=1 with addr/data, and stay in IDLE/issue.
    - If the head is a read: drive `mem_wr_rd`=0 with the address and go to WAIT.
  - Back-to-back writes issue one per cycle, so `mem_wr_rd` stays high across consecutive writes.
  - WAIT:
    - A counter loads RD_LAT at entry.
    - At the edge after the counter expires, capture `mem_rd_data` into `rsp_rdata`, set `rsp_valid`=1, and go to RESP.
    - No pops occur while in WAIT.
  - RESP:
    - Hold `rsp_valid` and `rsp_rdata` stable until `rsp_ready`.
    - On the handshake edge, clear `rsp_valid`; if the FIFO is non-empty, pop on that same edge (same issue rules as IDLE), otherwise go to IDLE.
    - No pops occur while `rsp_valid`=1 and `rsp_ready`=0; this is backpressure.
- Latency, for a push at edge k into an empty FIFO:
  - mem_* outputs update at edge k+1.
  - `mem` samples at edge k+2.
  - Read `rsp_valid` rises at edge k+2+RD_LAT.
- Ordering: strictly in-order; at most one read outstanding; a write never overtakes a queued read.
- Read-after-write to the same address returns the new data, because the write is sampled before the read issues.

Decomposition:
- Package `mem_ctrl_pkg` holds:
  - `req_t` packed struct {wr_rd, addr, wdata}.
  - State enum `ctrl_state_e` {IDLE, WAIT, RESP}.
  - Default ADDR_W/DATA_W constants.
  - `WR`=1 and `RD`=0 localparams, shared with the testbench interface.
- Sub-module `mem_req_fifo`: a parameterised synchronous FIFO of `req_t` with push/pop/full/empty.
- The FSM, latency counter and response register live in `mem_req_ctrl`.

Test Plan:
- Reset, then write addr 0x05 data 0xA5 -> at edge k+1 `mem_wr_rd`=1, `mem_addr`=0x05, `mem_wr_data`=0xA5 for exactly one cycle; `rsp_valid` stays 0.
- Write 0x10←0x3C, then read 0x10 with `rsp_ready`=1 -> `rsp_valid` pulses once with `rsp_rdata`=0x3C, RD_LAT+1 edges after the read issues.
- Push 4 writes with no gaps -> `req_ready`=0 after the 4th push; `mem_wr_rd` held high for 4 consecutive cycles; `req_ready` returns to 1 after the first pop.
- Two reads (0x01, 0x02) with `rsp_ready`=0 for 10 cycles -> first response 0x01 held stable; second read not issued (`mem_addr` stays 0x01) until the handshake; then 0x02 is returned.
- Assert rst low during WAIT with 3 requests queued -> outputs reach reset values immediately; after release, `busy`=0 and no response appears.
- Fill to DEPTH, then push+pop in the same cycle while full -> push is refused (`req_ready`=0); count drops to DEPTH-1; no entry is lost or duplicated.
